linear_transfomation_ctrl: RTL

Coefficient sequencer for the piecewise-linear transformation path. Holds a software-writable shadow bank of 16 control points, and on commit validates the bank (optional). At the next frame boundary it copies the shadow bank into the active bank that drives C00..C15 of the delta generator. It then pulses `cal_begin` and waits for `cal_valid`, so the coefficients never change mid-frame.

---
 rtl/linear_transfomation_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/linear_transfomation_ctrl.sv
// Coefficient sequencer: a shadow bank of 16 control points is copied to the active bank on a frame boundary.
// Define LT_MONO_CHECK_EN to reject non-monotonic shadow banks at commit time.
module linear_transfomation_ctrl #(
  parameter int DSIZE   = 12,
  parameter int DM      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [3:0]            cfg_addr,
  input  logic [DSIZE-1:0]      cfg_data,
  input  logic                  cfg_commit,
  output logic                  cfg_busy,
  input  logic                  frame_sync,
  output logic                  cal_begin,
  input  logic                  cal_valid,
  output logic [16*DSIZE-1:0]   coef_bus,
  output logic                  swap_done,
  output logic                  err_timeout,
  output logic                  err_mono
);

  // state      | meaning
  // IDLE       | shadow bank writable, waiting for cfg_commit
  // CHECK      | stepping monotonic compares over the shadow bank
  // WAIT_FRAME | waiting for frame_sync to copy shadow to active
  // CALC       | cal_begin issued, waiting for cal_valid or timeout
  // DONE       | one-cycle swap_done

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK      = 3'd1,
    WAIT_FRAME = 3'd2,
    CALC       = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [DSIZE-1:0] shadow [16];
  logic [DSIZE-1:0] active [16];
  logic [CW-1:0]    wait_cnt;
  logic [CW-1:0]    wait_cnt_inc;

  logic commit_acc;
  logic frame_load;
  logic calc_done;
  logic calc_timeout;

  logic busy_nxt;
  logic cal_begin_nxt;
  logic swap_done_nxt;
  logic err_timeout_nxt;

  function automatic logic [DSIZE-1:0] ident_point(input int k);
    return DSIZE'(DM * k);
  endfunction

  assign wait_cnt_inc = wait_cnt + CW'(1);
  assign commit_acc   = (state == IDLE) && cfg_commit;
  assign frame_load   = (state == WAIT_FRAME) && frame_sync;
  // cal_valid coincident with cal_begin belongs to a previous calculation
  assign calc_done    = (state == CALC) && !cal_begin && cal_valid;
  assign calc_timeout = (state == CALC) && !calc_done && (wait_cnt_inc == CW'(TIMEOUT));

`ifdef LT_MONO_CHECK_EN
  logic [3:0] chk_idx;
  logic       mono_ok;
  logic       err_mono_nxt;

  assign mono_ok = shadow[chk_idx] >= shadow[chk_idx - 4'd1];
`else
  assign err_mono = 1'b0;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_commit) begin
`ifdef LT_MONO_CHECK_EN
          state_nxt = CHECK;
`else
          state_nxt = WAIT_FRAME;
`endif
        end
      end
`ifdef LT_MONO_CHECK_EN
      CHECK: begin
        if (!mono_ok)              state_nxt = IDLE;
        else if (chk_idx == 4'd15) state_nxt = WAIT_FRAME;
      end
`endif
      WAIT_FRAME: if (frame_sync) state_nxt = CALC;
      CALC: begin
        if (calc_done)         state_nxt = DONE;
        else if (calc_timeout) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt        = (state_nxt != IDLE);
    cal_begin_nxt   = (state_nxt == CALC) && (state != CALC);
    swap_done_nxt   = (state_nxt == DONE);
    err_timeout_nxt = err_timeout;
    if (commit_acc)        err_timeout_nxt = 1'b0;
    else if (calc_timeout) err_timeout_nxt = 1'b1;
`ifdef LT_MONO_CHECK_EN
    err_mono_nxt = err_mono;
    if (commit_acc)                       err_mono_nxt = 1'b0;
    else if ((state == CHECK) && !mono_ok) err_mono_nxt = 1'b1;
`endif
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cfg_busy    <= 1'b0;
      cal_begin   <= 1'b0;
      swap_done   <= 1'b0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      cfg_busy    <= busy_nxt;
      cal_begin   <= cal_begin_nxt;
      swap_done   <= swap_done_nxt;
      err_timeout <= err_timeout_nxt;
      if (state == CALC) wait_cnt <= wait_cnt_inc;
      else               wait_cnt <= '0;
    end
  end

`ifdef LT_MONO_CHECK_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      err_mono <= 1'b0;
      chk_idx  <= 4'd0;
    end else begin
      err_mono <= err_mono_nxt;
      if (commit_acc)          chk_idx <= 4'd1;
      else if (state == CHECK) chk_idx <= chk_idx + 4'd1;
    end
  end
`endif

  // Writes are gated on IDLE so a commit in flight sees a frozen bank
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        shadow[k] <= ident_point(k);
        active[k] <= ident_point(k);
      end
    end else begin
      if (cfg_wr && (state == IDLE)) shadow[cfg_addr] <= cfg_data;
      if (frame_load) begin
        for (int k = 0; k < 16; k++) active[k] <= shadow[k];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_coef
    assign coef_bus[g*DSIZE +: DSIZE] = active[g];
  end

endmodule
